// File: rtl/gumnut_alu_pkg.sv
// rtl/gumnut_alu_pkg.sv - Gumnut ALU function encodings and sequencer state type.
package gumnut_alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_ADDC = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_SUBC = 3'd3;
    localparam logic [2:0] ALU_AND  = 3'd4;
    localparam logic [2:0] ALU_OR   = 3'd5;
    localparam logic [2:0] ALU_XOR  = 3'd6;
    localparam logic [2:0] ALU_MASK = 3'd7;

    localparam logic [1:0] SH_SHL = 2'd0;
    localparam logic [1:0] SH_SHR = 2'd1;
    localparam logic [1:0] SH_ROL = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/gumnut_alu_seq_if.sv
// rtl/gumnut_alu_seq_if.sv - request/response bundle of the sequenced Gumnut ALU.
// Overflow signals v_o/cc_v_o exist only with GUMNUT_ALU_OVF_EN defined.
interface gumnut_alu_seq_if #(parameter int DATA_W = 8);
    localparam int CNT_W = $clog2(DATA_W);

    logic              req_valid_i;
    logic              req_ready_o;
    logic              op_class_i;
    logic [2:0]        alu_fn_i;
    logic [1:0]        shift_fn_i;
    logic [DATA_W-1:0] a_i;
    logic [DATA_W-1:0] b_i;
    logic [CNT_W-1:0]  count_i;
    logic              cc_wr_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] result_o;
    logic              z_o;
    logic              c_o;
    logic              cc_z_o;
    logic              cc_c_o;
`ifdef GUMNUT_ALU_OVF_EN
    logic              v_o;
    logic              cc_v_o;

    modport master (
        output req_valid_i, op_class_i, alu_fn_i, shift_fn_i, a_i, b_i, count_i, cc_wr_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, result_o, z_o, c_o, cc_z_o, cc_c_o, v_o, cc_v_o
    );
    modport slave (
        input  req_valid_i, op_class_i, alu_fn_i, shift_fn_i, a_i, b_i, count_i, cc_wr_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, result_o, z_o, c_o, cc_z_o, cc_c_o, v_o, cc_v_o
    );
`else
    modport master (
        output req_valid_i, op_class_i, alu_fn_i, shift_fn_i, a_i, b_i, count_i, cc_wr_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, result_o, z_o, c_o, cc_z_o, cc_c_o
    );
    modport slave (
        input  req_valid_i, op_class_i, alu_fn_i, shift_fn_i, a_i, b_i, count_i, cc_wr_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, result_o, z_o, c_o, cc_z_o, cc_c_o
    );
`endif

endinterface

// File: rtl/gumnut_alu_arith.sv
// rtl/gumnut_alu_arith.sv - combinational Gumnut arith/logic unit with carry/borrow.
// Signed overflow output v_o exists only with GUMNUT_ALU_OVF_EN defined.
module gumnut_alu_arith
    import gumnut_alu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        alu_fn_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              cin_i,
`ifdef GUMNUT_ALU_OVF_EN
    output logic              v_o,
`endif
    output logic [DATA_W-1:0] result_o,
    output logic              c_o
);

    logic [DATA_W:0] a_x;
    logic [DATA_W:0] b_x;
    logic [DATA_W:0] cin_x;
    logic [DATA_W:0] sum_x;
    logic [DATA_W:0] diff_x;
    logic [DATA_W:0] res_x;
    logic            use_cin;

    // Bit DATA_W of the widened result is the carry for adds and the borrow for subtracts.
    always_comb begin
        use_cin = cin_i && ((alu_fn_i == ALU_ADDC) || (alu_fn_i == ALU_SUBC));
        a_x     = {1'b0, a_i};
        b_x     = {1'b0, b_i};
        cin_x   = {{DATA_W{1'b0}}, use_cin};
        sum_x   = a_x + b_x + cin_x;
        diff_x  = a_x - b_x - cin_x;
        case (alu_fn_i)
            ALU_ADD, ALU_ADDC: res_x = sum_x;
            ALU_SUB, ALU_SUBC: res_x = diff_x;
            ALU_AND:           res_x = {1'b0, a_i & b_i};
            ALU_OR:            res_x = {1'b0, a_i | b_i};
            ALU_XOR:           res_x = {1'b0, a_i ^ b_i};
            default:           res_x = {1'b0, a_i & ~b_i};
        endcase
    end

    assign result_o = res_x[DATA_W-1:0];
    assign c_o      = res_x[DATA_W];

`ifdef GUMNUT_ALU_OVF_EN
    localparam int MSB = DATA_W - 1;

    always_comb begin
        v_o = 1'b0;
        case (alu_fn_i)
            ALU_ADD, ALU_ADDC: v_o = (a_i[MSB] == b_i[MSB]) && (result_o[MSB] != a_i[MSB]);
            ALU_SUB, ALU_SUBC: v_o = (a_i[MSB] != b_i[MSB]) && (result_o[MSB] != a_i[MSB]);
            default:           v_o = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/gumnut_alu_seq.sv
// rtl/gumnut_alu_seq.sv - sequenced Gumnut ALU: handshake FSM, shifter, condition codes.
// Optional overflow flag and cc_v register enabled by GUMNUT_ALU_OVF_EN.
module gumnut_alu_seq
    import gumnut_alu_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ITER_SHIFT = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    gumnut_alu_seq_if.slave  bus
);

    localparam int CNT_W = $clog2(DATA_W);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              z_q, z_d;
    logic              c_q, c_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        sfn_q, sfn_d;
    logic              wr_q, wr_d;
    logic              cc_z_q, cc_z_d;
    logic              cc_c_q, cc_c_d;

    logic [DATA_W-1:0] ar_res;
    logic              ar_c;
`ifdef GUMNUT_ALU_OVF_EN
    logic              ar_v;
    logic              v_q, v_d;
    logic              cc_v_q, cc_v_d;
`endif

    gumnut_alu_arith #(.DATA_W(DATA_W)) u_arith (
        .alu_fn_i (bus.alu_fn_i),
        .a_i      (bus.a_i),
        .b_i      (bus.b_i),
        .cin_i    (cc_c_q),
`ifdef GUMNUT_ALU_OVF_EN
        .v_o      (ar_v),
`endif
        .result_o (ar_res),
        .c_o      (ar_c)
    );

    // Single-cycle shifter; also serves zero-count shifts in iterative builds.
    logic [DATA_W:0]   shl_ext;
    logic [DATA_W:0]   shr_ext;
    logic [CNT_W:0]    inv_cnt;
    logic [DATA_W-1:0] bs_res;
    logic              bs_c;

    always_comb begin
        shl_ext = {1'b0, bus.a_i} << bus.count_i;
        shr_ext = {bus.a_i, 1'b0} >> bus.count_i;
        inv_cnt = (CNT_W+1)'(DATA_W) - {1'b0, bus.count_i};
        case (bus.shift_fn_i)
            SH_SHL: begin
                bs_res = shl_ext[DATA_W-1:0];
                bs_c   = shl_ext[DATA_W];
            end
            SH_SHR: begin
                bs_res = shr_ext[DATA_W:1];
                bs_c   = shr_ext[0];
            end
            SH_ROL: begin
                bs_res = (bus.a_i << bus.count_i) | (bus.a_i >> inv_cnt);
                bs_c   = bs_res[0];
            end
            default: begin
                bs_res = (bus.a_i >> bus.count_i) | (bus.a_i << inv_cnt);
                bs_c   = bs_res[DATA_W-1];
            end
        endcase
    end

    // One-bit step of the iterative shifter, applied to the result register.
    logic [DATA_W-1:0] st_res;
    logic              st_c;

    always_comb begin
        case (sfn_q)
            SH_SHL: begin
                st_res = {result_q[DATA_W-2:0], 1'b0};
                st_c   = result_q[DATA_W-1];
            end
            SH_SHR: begin
                st_res = {1'b0, result_q[DATA_W-1:1]};
                st_c   = result_q[0];
            end
            SH_ROL: begin
                st_res = {result_q[DATA_W-2:0], result_q[DATA_W-1]};
                st_c   = result_q[DATA_W-1];
            end
            default: begin
                st_res = {result_q[0], result_q[DATA_W-1:1]};
                st_c   = result_q[0];
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        z_d      = z_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        sfn_d    = sfn_q;
        wr_d     = wr_q;
        cc_z_d   = cc_z_q;
        cc_c_d   = cc_c_q;
`ifdef GUMNUT_ALU_OVF_EN
        v_d      = v_q;
        cc_v_d   = cc_v_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    wr_d  = bus.cc_wr_i;
                    sfn_d = bus.shift_fn_i;
                    cnt_d = bus.count_i;
`ifdef GUMNUT_ALU_OVF_EN
                    v_d   = 1'b0;
`endif
                    if (!bus.op_class_i) begin
                        result_d = ar_res;
                        c_d      = ar_c;
                        z_d      = (ar_res == '0);
`ifdef GUMNUT_ALU_OVF_EN
                        v_d      = ar_v;
`endif
                        state_d  = ST_DONE;
                    end else if ((ITER_SHIFT == 0) || (bus.count_i == '0)) begin
                        result_d = bs_res;
                        c_d      = bs_c;
                        z_d      = (bs_res == '0);
                        state_d  = ST_DONE;
                    end else begin
                        result_d = bus.a_i;
                        c_d      = 1'b0;
                        z_d      = 1'b0;
                        state_d  = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                result_d = st_res;
                c_d      = st_c;
                z_d      = (st_res == '0);
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready_i) begin
                    state_d = ST_IDLE;
                    if (wr_q) begin
                        cc_z_d = z_q;
                        cc_c_d = c_q;
`ifdef GUMNUT_ALU_OVF_EN
                        cc_v_d = v_q;
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            sfn_q    <= SH_SHL;
            wr_q     <= 1'b0;
            cc_z_q   <= 1'b0;
            cc_c_q   <= 1'b0;
`ifdef GUMNUT_ALU_OVF_EN
            v_q      <= 1'b0;
            cc_v_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            z_q      <= z_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            sfn_q    <= sfn_d;
            wr_q     <= wr_d;
            cc_z_q   <= cc_z_d;
            cc_c_q   <= cc_c_d;
`ifdef GUMNUT_ALU_OVF_EN
            v_q      <= v_d;
            cc_v_q   <= cc_v_d;
`endif
        end
    end

    assign bus.req_ready_o = (state_q == ST_IDLE);
    assign bus.rsp_valid_o = (state_q == ST_DONE);
    assign bus.result_o    = result_q;
    assign bus.z_o         = z_q;
    assign bus.c_o         = c_q;
    assign bus.cc_z_o      = cc_z_q;
    assign bus.cc_c_o      = cc_c_q;
`ifdef GUMNUT_ALU_OVF_EN
    assign bus.v_o         = v_q;
    assign bus.cc_v_o      = cc_v_q;
`endif

endmodule

// File: tb/tb_gumnut_alu_seq.sv
// tb/tb_gumnut_alu_seq.sv - directed bench for gumnut_alu_seq (iterative and barrel builds).
// Overflow checks run only with GUMNUT_ALU_OVF_EN defined.
module tb_gumnut_alu_seq;
    import gumnut_alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    gumnut_alu_seq_if #(.DATA_W(8)) bi();
    gumnut_alu_seq_if #(.DATA_W(8)) bb();

    gumnut_alu_seq #(.DATA_W(8), .ITER_SHIFT(1)) dut   (.clk_i(clk), .rst_i(rst), .bus(bi));
    gumnut_alu_seq #(.DATA_W(8), .ITER_SHIFT(0)) dut_b (.clk_i(clk), .rst_i(rst), .bus(bb));

    typedef struct packed {
        logic [2:0] fn;
        logic [7:0] a;
        logic [7:0] b;
        logic       wr;
        logic [7:0] r;
        logic       z;
        logic       c;
        logic       ccz;
        logic       ccc;
    } arith_vec_t;

    typedef struct packed {
        logic [1:0] sfn;
        logic [7:0] a;
        logic [2:0] cnt;
        logic [7:0] r;
        logic       z;
        logic       c;
        int         lat;
    } shift_vec_t;

    task automatic init_inputs();
        bi.req_valid_i = 0; bi.op_class_i = 0; bi.alu_fn_i = 0; bi.shift_fn_i = 0;
        bi.a_i = 0; bi.b_i = 0; bi.count_i = 0; bi.cc_wr_i = 0; bi.rsp_ready_i = 0;
        bb.req_valid_i = 0; bb.op_class_i = 0; bb.alu_fn_i = 0; bb.shift_fn_i = 0;
        bb.a_i = 0; bb.b_i = 0; bb.count_i = 0; bb.cc_wr_i = 0; bb.rsp_ready_i = 0;
    endtask

    // Issue on the iterative DUT; returns at the first negedge with rsp_valid high (lat counts edges).
    task automatic issue_i(input logic cls, input logic [2:0] fn, input logic [1:0] sfn,
                           input logic [7:0] a, input logic [7:0] b, input logic [2:0] cnt,
                           input logic wr, output int lat);
        @(negedge clk);
        bi.op_class_i = cls; bi.alu_fn_i = fn; bi.shift_fn_i = sfn;
        bi.a_i = a; bi.b_i = b; bi.count_i = cnt; bi.cc_wr_i = wr; bi.req_valid_i = 1;
        @(posedge clk);
        #1 bi.req_valid_i = 0;
        for (lat = 1; lat <= 40; lat++) begin
            @(negedge clk);
            if (bi.rsp_valid_o) break;
        end
    endtask

    task automatic issue_b(input logic [1:0] sfn, input logic [7:0] a, input logic [2:0] cnt,
                           output int lat);
        @(negedge clk);
        bb.op_class_i = 1; bb.shift_fn_i = sfn; bb.a_i = a; bb.b_i = 8'h5A;
        bb.count_i = cnt; bb.cc_wr_i = 0; bb.req_valid_i = 1;
        @(posedge clk);
        #1 bb.req_valid_i = 0;
        for (lat = 1; lat <= 40; lat++) begin
            @(negedge clk);
            if (bb.rsp_valid_o) break;
        end
    endtask

    task automatic handshake_i();
        bi.rsp_ready_i = 1;
        @(posedge clk);
        #1 bi.rsp_ready_i = 0;
    endtask

    task automatic handshake_b();
        bb.rsp_ready_i = 1;
        @(posedge clk);
        #1 bb.rsp_ready_i = 0;
    endtask

    task automatic test_reset();
        init_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        n_cmp++;
        if ({bi.req_ready_o, bi.rsp_valid_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_handshake: got %b expected 10", {bi.req_ready_o, bi.rsp_valid_o});
        end
        n_cmp++;
        if ({bi.result_o, bi.z_o, bi.c_o} !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_result: got %h expected 000", {bi.result_o, bi.z_o, bi.c_o});
        end
        n_cmp++;
        if ({bi.cc_z_o, bi.cc_c_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_cc: got %b expected 00", {bi.cc_z_o, bi.cc_c_o});
        end
    endtask

    task automatic test_arith();
        arith_vec_t tv [9];
        int lat;
        tv = '{
            '{ALU_ADD,  8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1},
            '{ALU_ADDC, 8'h10, 8'h20, 1'b0, 8'h31, 1'b0, 1'b0, 1'b1, 1'b1},
            '{ALU_SUB,  8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b1},
            '{ALU_SUBC, 8'h10, 8'h05, 1'b0, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b1},
            '{ALU_AND,  8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b1},
            '{ALU_OR,   8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1},
            '{ALU_XOR,  8'hAA, 8'hAA, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1},
            '{ALU_MASK, 8'hF0, 8'h30, 1'b1, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{ALU_ADDC, 8'h80, 8'h80, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1}
        };
        for (int i = 0; i < 9; i++) begin
            issue_i(1'b0, tv[i].fn, 2'd0, tv[i].a, tv[i].b, 3'd0, tv[i].wr, lat);
            n_cmp++;
            if (lat != 1) begin
                n_fail++;
                $display("FAIL arith_latency[%0d]: got %0d expected 1", i, lat);
            end
            n_cmp++;
            if ({bi.result_o, bi.z_o, bi.c_o} !== {tv[i].r, tv[i].z, tv[i].c}) begin
                n_fail++;
                $display("FAIL arith_result[%0d]: got r=%h z=%b c=%b expected r=%h z=%b c=%b",
                         i, bi.result_o, bi.z_o, bi.c_o, tv[i].r, tv[i].z, tv[i].c);
            end
            handshake_i();
            n_cmp++;
            if ({bi.cc_z_o, bi.cc_c_o} !== {tv[i].ccz, tv[i].ccc}) begin
                n_fail++;
                $display("FAIL arith_cc[%0d]: got %b%b expected %b%b",
                         i, bi.cc_z_o, bi.cc_c_o, tv[i].ccz, tv[i].ccc);
            end
        end
    endtask

    task automatic test_iter_shift();
        shift_vec_t tv [8];
        int lat;
        tv = '{
            '{SH_ROL, 8'h81, 3'd3, 8'h0C, 1'b0, 1'b0, 4},
            '{SH_SHR, 8'h03, 3'd1, 8'h01, 1'b0, 1'b1, 2},
            '{SH_SHL, 8'h80, 3'd1, 8'h00, 1'b1, 1'b1, 2},
            '{SH_ROR, 8'h01, 3'd1, 8'h80, 1'b0, 1'b1, 2},
            '{SH_SHL, 8'hFF, 3'd0, 8'hFF, 1'b0, 1'b0, 1},
            '{SH_ROL, 8'hA5, 3'd0, 8'hA5, 1'b0, 1'b1, 1},
            '{SH_SHR, 8'h80, 3'd7, 8'h01, 1'b0, 1'b0, 8},
            '{SH_ROR, 8'h0F, 3'd4, 8'hF0, 1'b0, 1'b1, 5}
        };
        for (int i = 0; i < 8; i++) begin
            issue_i(1'b1, ALU_AND, tv[i].sfn, tv[i].a, 8'h33, tv[i].cnt, 1'b0, lat);
            n_cmp++;
            if (lat != tv[i].lat) begin
                n_fail++;
                $display("FAIL ishift_latency[%0d]: got %0d expected %0d", i, lat, tv[i].lat);
            end
            n_cmp++;
            if ({bi.result_o, bi.z_o, bi.c_o} !== {tv[i].r, tv[i].z, tv[i].c}) begin
                n_fail++;
                $display("FAIL ishift_result[%0d]: got r=%h z=%b c=%b expected r=%h z=%b c=%b",
                         i, bi.result_o, bi.z_o, bi.c_o, tv[i].r, tv[i].z, tv[i].c);
            end
            handshake_i();
        end
        n_cmp++;
        if ({bi.cc_z_o, bi.cc_c_o} !== 2'b11) begin
            n_fail++;
            $display("FAIL ishift_cc_hold: got %b%b expected 11", bi.cc_z_o, bi.cc_c_o);
        end
    endtask

    task automatic test_barrel_shift();
        shift_vec_t tv [8];
        int lat;
        tv = '{
            '{SH_ROL, 8'h81, 3'd3, 8'h0C, 1'b0, 1'b0, 1},
            '{SH_SHL, 8'h81, 3'd1, 8'h02, 1'b0, 1'b1, 1},
            '{SH_SHR, 8'h03, 3'd1, 8'h01, 1'b0, 1'b1, 1},
            '{SH_ROR, 8'h01, 3'd1, 8'h80, 1'b0, 1'b1, 1},
            '{SH_SHL, 8'h0F, 3'd4, 8'hF0, 1'b0, 1'b0, 1},
            '{SH_SHR, 8'h18, 3'd4, 8'h01, 1'b0, 1'b1, 1},
            '{SH_ROR, 8'h81, 3'd0, 8'h81, 1'b0, 1'b1, 1},
            '{SH_SHR, 8'h01, 3'd1, 8'h00, 1'b1, 1'b1, 1}
        };
        for (int i = 0; i < 8; i++) begin
            issue_b(tv[i].sfn, tv[i].a, tv[i].cnt, lat);
            n_cmp++;
            if (lat != tv[i].lat) begin
                n_fail++;
                $display("FAIL bshift_latency[%0d]: got %0d expected %0d", i, lat, tv[i].lat);
            end
            n_cmp++;
            if ({bb.result_o, bb.z_o, bb.c_o} !== {tv[i].r, tv[i].z, tv[i].c}) begin
                n_fail++;
                $display("FAIL bshift_result[%0d]: got r=%h z=%b c=%b expected r=%h z=%b c=%b",
                         i, bb.result_o, bb.z_o, bb.c_o, tv[i].r, tv[i].z, tv[i].c);
            end
            handshake_b();
        end
    endtask

    task automatic test_reset_mid_shift();
        logic saw_valid;
        @(negedge clk);
        bi.op_class_i = 1; bi.shift_fn_i = SH_ROL; bi.a_i = 8'h81; bi.count_i = 3'd5;
        bi.cc_wr_i = 1; bi.req_valid_i = 1;
        @(posedge clk);
        #1 bi.req_valid_i = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        #1;
        n_cmp++;
        if ({bi.req_ready_o, bi.rsp_valid_o, bi.result_o, bi.cc_c_o} !== {2'b10, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_async: got rdy=%b vld=%b r=%h ccc=%b expected 1 0 00 0",
                     bi.req_ready_o, bi.rsp_valid_o, bi.result_o, bi.cc_c_o);
        end
        @(negedge clk);
        rst = 0;
        saw_valid = 0;
        repeat (10) begin
            @(negedge clk);
            if (bi.rsp_valid_o) saw_valid = 1;
        end
        n_cmp++;
        if (saw_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_response: got rsp_valid seen=%b expected 0", saw_valid);
        end
        n_cmp++;
        if ({bi.req_ready_o, bi.cc_z_o, bi.cc_c_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL rst_after: got %b expected 100", {bi.req_ready_o, bi.cc_z_o, bi.cc_c_o});
        end
    endtask

    task automatic test_stall();
        int lat;
        issue_i(1'b0, ALU_ADD, 2'd0, 8'hFF, 8'h01, 3'd0, 1'b1, lat);
        // A second request held during DONE must be ignored.
        bi.alu_fn_i = ALU_SUB; bi.a_i = 8'h05; bi.b_i = 8'h07; bi.req_valid_i = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({bi.rsp_valid_o, bi.result_o, bi.z_o, bi.c_o, bi.req_ready_o, bi.cc_z_o, bi.cc_c_o}
                !== {1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got vld=%b r=%h z=%b c=%b rdy=%b cc=%b%b expected 1 00 1 1 0 00",
                         k, bi.rsp_valid_o, bi.result_o, bi.z_o, bi.c_o, bi.req_ready_o,
                         bi.cc_z_o, bi.cc_c_o);
            end
        end
        bi.req_valid_i = 0;
        handshake_i();
        n_cmp++;
        if ({bi.req_ready_o, bi.rsp_valid_o, bi.cc_z_o, bi.cc_c_o} !== 4'b1011) begin
            n_fail++;
            $display("FAIL stall_commit: got %b expected 1011",
                     {bi.req_ready_o, bi.rsp_valid_o, bi.cc_z_o, bi.cc_c_o});
        end
    endtask

`ifdef GUMNUT_ALU_OVF_EN
    task automatic test_overflow();
        int lat;
        issue_i(1'b0, ALU_ADD, 2'd0, 8'h7F, 8'h01, 3'd0, 1'b1, lat);
        n_cmp++;
        if ({bi.result_o, bi.v_o} !== {8'h80, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_add: got r=%h v=%b expected 80 1", bi.result_o, bi.v_o);
        end
        handshake_i();
        n_cmp++;
        if (bi.cc_v_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_cc_set: got %b expected 1", bi.cc_v_o);
        end
        issue_i(1'b0, ALU_SUB, 2'd0, 8'h80, 8'h01, 3'd0, 1'b0, lat);
        n_cmp++;
        if ({bi.result_o, bi.v_o} !== {8'h7F, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_sub: got r=%h v=%b expected 7F 1", bi.result_o, bi.v_o);
        end
        handshake_i();
        issue_i(1'b0, ALU_XOR, 2'd0, 8'h7F, 8'h80, 3'd0, 1'b1, lat);
        n_cmp++;
        if (bi.v_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_logic: got %b expected 0", bi.v_o);
        end
        handshake_i();
        n_cmp++;
        if (bi.cc_v_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_cc_clear: got %b expected 0", bi.cc_v_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_arith();
        test_iter_shift();
        test_barrel_shift();
        test_reset_mid_shift();
        test_stall();
`ifdef GUMNUT_ALU_OVF_EN
        test_overflow();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
